// File: rtl/prog_loader.sv
// prog_loader: assembles a length-prefixed big-endian byte stream into 16-bit
// instruction-memory writes, then raises ready (or sticky err on a bad stream).
// Optional running-XOR checksum byte enabled by `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int                 ADDR_W     = 8,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              load,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              ready,
  output logic              err
);

  typedef enum logic [2:0] {
    LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE, ERR
`ifdef PROG_LOADER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  // State reached once the last word (or an empty length) has been accepted.
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t LAST_ST = CSUM;
`else
  localparam state_t LAST_ST = DONE;
`endif

  // Largest legal program length; counter is one bit wider to represent it.
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [15:0]         im_wdata_q, im_wdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [7:0]          hi_q, hi_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                hs;
  logic [15:0]         n_full;
  logic [ADDR_W:0]     cnt_next;
  logic                restart;

  assign hs       = in_valid & in_ready_q;
  assign n_full   = {len_hi_q, in_data};
  assign cnt_next = cnt_q + (ADDR_W+1)'(1);
  assign restart  = load & ((state_q == DONE) | (state_q == ERR));

  assign in_ready = in_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign ready    = ready_q;
  assign err      = err_q;

  // State register; reset aborts any load in progress.
  always_ff @(posedge clk) begin
    if (rst) state_q <= LEN_HI;
    else     state_q <= state_d;
  end

  // Next-state logic: every receiving state advances only on a handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LEN_HI:  if (hs) state_d = LEN_LO;
      LEN_LO:  if (hs) begin
                 if ({1'b0, n_full} > MAX_N) state_d = ERR;
                 else if (n_full == 16'd0)    state_d = LAST_ST;
                 else                         state_d = DATA_HI;
               end
      DATA_HI: if (hs) state_d = DATA_LO;
      DATA_LO: if (hs) state_d = (cnt_next == len_q) ? LAST_ST : DATA_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM:    if (hs) state_d = (in_data == csum_q) ? DONE : ERR;
`endif
      DONE:    if (load) state_d = LEN_HI;
      ERR:     if (load) state_d = LEN_HI;
      default: state_d = LEN_HI;
    endcase
  end

  // Output and datapath next values; status flags lag their state by one edge.
  always_comb begin
    in_ready_d = (state_d != DONE) && (state_d != ERR);
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    ready_d    = (state_q == DONE) && !load;
    err_d      = (state_q == ERR) && !load;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    if (hs) begin
      case (state_q)
        LEN_HI:  len_hi_d = in_data;
        LEN_LO:  begin
                   len_d = n_full[ADDR_W:0];
                   cnt_d = '0;
                 end
        DATA_HI: hi_d = in_data;
        DATA_LO: begin
                   im_we_d    = 1'b1;
                   im_addr_d  = START_ADDR + cnt_q[ADDR_W-1:0];
                   im_wdata_d = {hi_q, in_data};
                   cnt_d      = cnt_next;
                 end
        default: ;
      endcase
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d = csum_q;
    if (hs && (state_q == LEN_HI || state_q == LEN_LO ||
               state_q == DATA_HI || state_q == DATA_LO))
      csum_d = csum_q ^ in_data;
    if (restart) csum_d = 8'd0;
`endif
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      len_hi_q   <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (start address 0 and 254) share one
// byte stream; writes are logged and compared with a stream-level model.
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, load;
  logic [7:0] in_data;
  logic in_ready_a, im_we_a, ready_a, err_a;
  logic in_ready_b, im_we_b, ready_b, err_b;
  logic [7:0] im_addr_a, im_addr_b;
  logic [15:0] im_wdata_a, im_wdata_b;

  prog_loader #(.ADDR_W(8), .START_ADDR(8'd0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .load(load), .im_we(im_we_a), .im_addr(im_addr_a), .im_wdata(im_wdata_a),
    .ready(ready_a), .err(err_a));

  prog_loader #(.ADDR_W(8), .START_ADDR(8'd254)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .load(load), .im_we(im_we_b), .im_addr(im_addr_b), .im_wdata(im_wdata_b),
    .ready(ready_b), .err(err_b));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [23:0] wq_a[$], wq_b[$], exp_a[$], exp_b[$];
  logic [7:0]  stream[$];
  bit          exp_err;
  bit          corrupt;

  // Write-port log, sampled away from the active edge.
  always @(negedge clk) begin
    if (im_we_a) wq_a.push_back({im_addr_a, im_wdata_a});
    if (im_we_b) wq_b.push_back({im_addr_b, im_wdata_b});
  end

  task automatic clear_logs();
    wq_a.delete();
    wq_b.delete();
  endtask

  // Expected writes for the current stream: N words at (start+i) mod 256.
  task automatic model_build();
    int n;
    n = {stream[0], stream[1]};
    exp_a.delete();
    exp_b.delete();
    exp_err = (n > 256) || (CSUM_EN && corrupt);
    if (n <= 256)
      for (int i = 0; i < n; i++) begin
        exp_a.push_back({8'(i), stream[2+2*i], stream[3+2*i]});
        exp_b.push_back({8'(254 + i), stream[2+2*i], stream[3+2*i]});
      end
  endtask

  function automatic int log_diff();
    int d = 0;
    if (wq_a.size() != exp_a.size()) d++;
    else foreach (exp_a[i]) if (wq_a[i] !== exp_a[i]) d++;
    if (wq_b.size() != exp_b.size()) d++;
    else foreach (exp_b[i]) if (wq_b[i] !== exp_b[i]) d++;
    return d;
  endfunction

  // Present one byte until it is accepted, then stall for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit rdy;
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50; t++) begin
      rdy = in_ready_a;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      #1;
    end
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL handshake_timeout byte=%h in_ready=%b required 1", b, in_ready_a);
    end
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Whole stream plus checksum byte (when enabled and the length is legal).
  task automatic send_stream(input int gapmax);
    logic [7:0] x = 8'h00;
    foreach (stream[i]) begin
      x ^= stream[i];
      send_byte(stream[i], $urandom_range(gapmax, 0));
    end
    if (CSUM_EN && ({stream[0], stream[1]} <= 16'd256))
      send_byte(corrupt ? (x ^ 8'h5A) : x, 0);
  endtask

  task automatic wait_end();
    bit ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk);
      #1;
      if ((ready_a | err_a) && (ready_b | err_b)) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL end_timeout ready=%b err=%b required one of them 1", ready_a, err_a);
    end
  endtask

  task automatic do_load();
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; load = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({in_ready_a, im_we_a, im_addr_a, im_wdata_a, ready_a, err_a} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h required 0",
               {in_ready_a, im_we_a, im_addr_a, im_wdata_a, ready_a, err_a});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if ({in_ready_a, ready_a, err_a} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release in_ready/ready/err=%b required 100", {in_ready_a, ready_a, err_a});
    end
  endtask

  task automatic test_basic();
    logic [7:0] x;
    clear_logs();
    corrupt = 1'b0;
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    model_build();
    send_byte(8'h00, 0);
    do_load();  // not in DONE/ERR: must be ignored
    x = 8'h00 ^ 8'h02 ^ 8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD;
    for (int i = 1; i < 6; i++) send_byte(stream[i], 0);
    n_chk++;
    if ({im_we_a, im_addr_a, im_wdata_a} !== {1'b1, 8'h01, 16'hABCD}) begin
      n_fail++;
      $display("FAIL basic_last_write got we/addr/data=%h required 101abcd",
               {im_we_a, im_addr_a, im_wdata_a});
    end
    if (CSUM_EN) send_byte(x, 0);
    n_chk++;
    if (ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ready_early got %b required 0", ready_a);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if ({ready_a, in_ready_a, im_we_a, err_a} !== 4'b1000) begin
      n_fail++;
      $display("FAIL basic_ready got ready/in_ready/we/err=%b required 1000",
               {ready_a, in_ready_a, im_we_a, err_a});
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (log_diff() !== 0 || ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_writes diffs=%0d ready=%b required 0 diffs ready 1", log_diff(), ready_a);
    end
    do_load();
    n_chk++;
    if ({ready_a, err_a, in_ready_a} !== 3'b001) begin
      n_fail++;
      $display("FAIL basic_reload ready/err/in_ready=%b required 001", {ready_a, err_a, in_ready_a});
    end
  endtask

  task automatic test_stall();
    clear_logs();
    corrupt = 1'b0;
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    model_build();
    foreach (stream[i]) send_byte(stream[i], 3);
    if (CSUM_EN) send_byte(8'h42, 3);
    wait_end();
    n_chk++;
    if (log_diff() !== 0 || ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_writes diffs=%0d writes=%0d ready=%b required 0 diffs 2 writes ready 1",
               log_diff(), wq_a.size(), ready_a);
    end
    do_load();
  endtask

  task automatic test_oversize();
    clear_logs();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    n_chk++;
    if (err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL oversize_err_early got %b required 0", err_a);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if ({err_a, ready_a, in_ready_a, err_b} !== 4'b1001) begin
      n_fail++;
      $display("FAIL oversize_err got err/ready/in_ready/err_b=%b required 1001",
               {err_a, ready_a, in_ready_a, err_b});
    end
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if (wq_a.size() != 0 || err_a !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize_hold writes=%0d err=%b required 0 writes err 1", wq_a.size(), err_a);
    end
    do_load();
    n_chk++;
    if ({err_a, ready_a, in_ready_a} !== 3'b001) begin
      n_fail++;
      $display("FAIL oversize_reload err/ready/in_ready=%b required 001", {err_a, ready_a, in_ready_a});
    end
    corrupt = 1'b0;
    stream = '{8'h00, 8'h01, 8'hBE, 8'hEF};
    model_build();
    send_stream(1);
    wait_end();
    n_chk++;
    if (log_diff() !== 0 || {ready_a, err_a} !== 2'b10) begin
      n_fail++;
      $display("FAIL oversize_recover diffs=%0d ready/err=%b required 0 diffs 10", log_diff(), {ready_a, err_a});
    end
    do_load();
  endtask

  task automatic test_wrap();
    clear_logs();
    corrupt = 1'b0;
    stream = '{8'h00, 8'h04};
    for (int i = 0; i < 8; i++) stream.push_back(8'($urandom));
    model_build();
    send_stream(2);
    wait_end();
    n_chk++;
    if (wq_b.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_count got %0d writes required 4", wq_b.size());
    end else if ({wq_b[0][23:16], wq_b[1][23:16], wq_b[2][23:16], wq_b[3][23:16]} !== 32'hFEFF0001) begin
      n_fail++;
      $display("FAIL wrap_addr got %h %h %h %h required fe ff 00 01",
               wq_b[0][23:16], wq_b[1][23:16], wq_b[2][23:16], wq_b[3][23:16]);
    end
    n_chk++;
    if (log_diff() !== 0) begin
      n_fail++;
      $display("FAIL wrap_data diffs=%0d required 0", log_diff());
    end
    do_load();
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_logs();
    foreach (stream[i]) stream.delete();
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'h27, 0);
    @(posedge clk);
    #1;
    n_chk++;
    if ({ready_a, err_a} !== 2'b10) begin
      n_fail++;
      $display("FAIL csum_good ready/err=%b required 10", {ready_a, err_a});
    end
    do_load();
    clear_logs();
    send_byte(8'h00, 0); send_byte(8'h01, 1); send_byte(8'h12, 0); send_byte(8'h34, 2);
    send_byte(8'h28, 0);
    @(posedge clk);
    #1;
    n_chk++;
    if ({ready_a, err_a} !== 2'b01 || wq_a.size() != 1) begin
      n_fail++;
      $display("FAIL csum_bad ready/err=%b writes=%0d required 01 and 1 write", {ready_a, err_a}, wq_a.size());
    end else if (wq_a[0] !== 24'h001234) begin
      n_fail++;
      $display("FAIL csum_bad_write got %h required 001234", wq_a[0]);
    end
    do_load();
  endtask
`endif

  task automatic test_random();
    int n;
    for (int it = 0; it < 20; it++) begin
      clear_logs();
      corrupt = ($urandom_range(3, 0) == 0);
      n = (it % 7 == 3) ? $urandom_range(300, 257) : $urandom_range(6, 0);
      stream = '{8'(n >> 8), 8'(n)};
      if (n <= 256)
        for (int i = 0; i < 2*n; i++) stream.push_back(8'($urandom));
      model_build();
      send_stream(2);
      wait_end();
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (log_diff() !== 0 || {ready_a, err_a, ready_b, err_b} !== {!exp_err, exp_err, !exp_err, exp_err}) begin
        n_fail++;
        $display("FAIL random_%0d n=%0d diffs=%0d ready/err=%b%b required %b%b",
                 it, n, log_diff(), ready_a, err_a, !exp_err, exp_err);
      end
      do_load();
      n_chk++;
      if ({ready_a, err_a, in_ready_a} !== 3'b001) begin
        n_fail++;
        $display("FAIL random_reload_%0d ready/err/in_ready=%b required 001", it, {ready_a, err_a, in_ready_a});
      end
    end
  endtask

  task automatic test_midload_reset();
    clear_logs();
    send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h12, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if ({in_ready_a, im_we_a, im_addr_a, im_wdata_a, ready_a, err_a, in_ready_b, ready_b, err_b} !== 31'd0) begin
      n_fail++;
      $display("FAIL midload_reset in_ready/we/ready/err=%b%b%b%b required 0000",
               in_ready_a, im_we_a, ready_a, err_a);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    corrupt = 1'b0;
    stream = '{8'h00, 8'h02, 8'h56, 8'h78, 8'h9A, 8'hBC};
    model_build();
    send_stream(1);
    wait_end();
    n_chk++;
    if (log_diff() !== 0 || {ready_a, err_a} !== 2'b10) begin
      n_fail++;
      $display("FAIL midload_fresh diffs=%0d ready/err=%b required 0 diffs 10", log_diff(), {ready_a, err_a});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_oversize();
    test_wrap();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    test_midload_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
